hist_acq_sequencer: RTL and testbench

Time-division scheduler in front of the histogram builder. It takes timestamp requests from `NPIX` pixel TDC channels and serialises them into the builder's single write port in strict pixel order. It runs two passes: a coarse pass (CH), then a fine pass (FH). Between passes it waits for the builder's peak result, and at the end it reports completion to the frame controller.

---
 rtl/hist_acq_sequencer.sv | 164 ++++++++++++++++
 tb/tb_hist_acq_sequencer.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hist_acq_sequencer.sv
// Time-division scheduler that serialises pixel TDC samples into the histogram builder, coarse pass then fine pass.
// Optional stall timeout with pixel skip is enabled by defining HSEQ_TIMEOUT_EN.
module hist_acq_sequencer #(
  parameter  int NPIX     = 4,
  parameter  int NP       = 12,
  parameter  int DATA_NUM = 2,
  parameter  int ACQ_NUM  = 16,
  parameter  int TIMEOUT  = 255,
  localparam int PW       = (NPIX > 1) ? $clog2(NPIX) : 1
) (
  input  logic               clk,
  input  logic               res,
  input  logic               start,
  input  logic               abort,
  input  logic [NPIX-1:0]    req,
  input  logic [NPIX*NP-1:0] data_in,
  output logic [NPIX-1:0]    ack,
  output logic               hb_wr_en,
  output logic [NP-1:0]      hb_data,
  output logic [PW-1:0]      hb_pixel,
  output logic               hb_pass,
  output logic               hb_clear,
  input  logic               hb_peak_done,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam int SW = (DATA_NUM > 1) ? $clog2(DATA_NUM) : 1;
  localparam int AW = (ACQ_NUM > 1) ? $clog2(ACQ_NUM) : 1;

  localparam logic [SW-1:0] SMP_LAST = SW'(DATA_NUM - 1);
  localparam logic [PW-1:0] PIX_LAST = PW'(NPIX - 1);
  localparam logic [AW-1:0] ACQ_LAST = AW'(ACQ_NUM - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_ACQ,
    S_WAIT_PEAK,
    S_DONE
  } state_t;

  state_t        state, state_next;
  logic [SW-1:0] smp;
  logic [PW-1:0] pix;
  logic [AW-1:0] acq;
  logic          take;
  logic          skip;
  logic          adv_pix;
  logic          last_slot;

`ifdef HSEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] STALL_LAST = TW'(TIMEOUT - 1);
  logic [TW-1:0] stall_cnt;
`endif

  assign last_slot = (pix == PIX_LAST) && (acq == ACQ_LAST);
  assign adv_pix   = (take && (smp == SMP_LAST)) || skip;

  // NOTE: every signal driven here gets a default first so no path leaves it unassigned and infers a latch.
  always_comb begin
    state_next = state;
    ack        = '0;
    take       = 1'b0;
    skip       = 1'b0;
    case (state)
      S_IDLE: if (start) state_next = S_CLEAR;
      S_CLEAR: state_next = S_ACQ;
      S_ACQ: begin
        ack[pix] = req[pix];
        take     = req[pix];
`ifdef HSEQ_TIMEOUT_EN
        skip     = !req[pix] && (stall_cnt == STALL_LAST);
`endif
        if ((take && (smp == SMP_LAST) && last_slot) || (skip && last_slot))
          state_next = S_WAIT_PEAK;
      end
      S_WAIT_PEAK: if (hb_peak_done) state_next = hb_pass ? S_DONE : S_CLEAR;
      S_DONE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    // Abort suppresses the grant as well, so no pixel loses a sample that would never be written.
    if (abort) begin
      state_next = S_IDLE;
      ack        = '0;
      take       = 1'b0;
      skip       = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state <= S_IDLE;
      smp   <= '0;
      pix   <= '0;
      acq   <= '0;
    end else begin
      state <= state_next;
      if (abort || state == S_CLEAR) begin
        smp <= '0;
        pix <= '0;
        acq <= '0;
      end else begin
        if (take && smp != SMP_LAST) smp <= smp + 1'b1;
        else if (adv_pix)            smp <= '0;
        if (adv_pix) begin
          if (pix == PIX_LAST) begin
            pix <= '0;
            acq <= (acq == ACQ_LAST) ? '0 : acq + 1'b1;
          end else begin
            pix <= pix + 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      hb_wr_en <= 1'b0;
      hb_data  <= '0;
      hb_pixel <= '0;
    end else begin
      hb_wr_en <= take;
      if (take) begin
        hb_data  <= data_in[int'(pix)*NP +: NP];
        hb_pixel <= pix;
      end
    end
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      hb_pass <= 1'b0;
    end else if (abort || state == S_DONE || (state == S_IDLE && start)) begin
      hb_pass <= 1'b0;
    end else if (state == S_WAIT_PEAK && hb_peak_done && !hb_pass) begin
      hb_pass <= 1'b1;
    end
  end

`ifdef HSEQ_TIMEOUT_EN
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      stall_cnt <= '0;
      err       <= 1'b0;
    end else begin
      stall_cnt <= (state == S_ACQ && !take && !skip && !abort) ? stall_cnt + 1'b1 : '0;
      if (state == S_IDLE && start && !abort) err <= 1'b0;
      else if (skip)                          err <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

  assign hb_clear = (state == S_CLEAR);
  assign busy     = (state != S_IDLE);
  assign done     = (state == S_DONE);

endmodule

// File: tb/tb_hist_acq_sequencer.sv
// Self-checking bench for hist_acq_sequencer: vector table for control corners, then randomized
// pixel traffic checked against an expected-write queue built from the pass/acquisition/pixel order.
module tb_hist_acq_sequencer;

  localparam int NPIX     = 4;
  localparam int NP       = 12;
  localparam int DATA_NUM = 2;
  localparam int ACQ_NUM  = 3;
  localparam int TIMEOUT  = 8;
  localparam int NSMP     = DATA_NUM * ACQ_NUM;
  localparam int PASS_WR  = NPIX * NSMP;

  logic               clk = 1'b0;
  logic               res = 1'b0;
  logic               start = 1'b0;
  logic               abort = 1'b0;
  logic [NPIX-1:0]    req = '0;
  logic [NPIX*NP-1:0] data_in = '0;
  logic               hb_peak_done = 1'b0;
  logic [NPIX-1:0]    ack;
  logic               hb_wr_en;
  logic [NP-1:0]      hb_data;
  logic [1:0]         hb_pixel;
  logic               hb_pass;
  logic               hb_clear;
  logic               busy;
  logic               done;
  logic               err;

  always #5 clk = ~clk;

  hist_acq_sequencer #(
    .NPIX(NPIX), .NP(NP), .DATA_NUM(DATA_NUM), .ACQ_NUM(ACQ_NUM), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .res(res), .start(start), .abort(abort), .req(req), .data_in(data_in),
    .ack(ack), .hb_wr_en(hb_wr_en), .hb_data(hb_data), .hb_pixel(hb_pixel),
    .hb_pass(hb_pass), .hb_clear(hb_clear), .hb_peak_done(hb_peak_done),
    .busy(busy), .done(done), .err(err)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Pixel environment and reference model.
  typedef struct {
    int          pix;
    logic [NP-1:0] data;
    logic        pass;
  } wr_t;

  logic [NP-1:0]   ts [2][NPIX][NSMP];
  int              cnt [NPIX];
  logic [NPIX-1:0] en_mask = '1;
  int              req_pct = 100;
  bit              auto_peak = 1'b1;
  wr_t             exp_q [$];
  int              pass_no = -1;
  int              clears, writes, dones;
  int              peak_wait = -1;
  logic [NPIX-1:0] ack_seen;

  task automatic build_pass(input int pass);
    wr_t w;
    exp_q.delete();
    for (int a = 0; a < ACQ_NUM; a++)
      for (int p = 0; p < NPIX; p++)
        if (en_mask[p])
          for (int s = 0; s < DATA_NUM; s++) begin
            w.pix  = p;
            w.data = ts[pass % 2][p][a*DATA_NUM + s];
            w.pass = (pass % 2) == 1;
            exp_q.push_back(w);
          end
  endtask

  task automatic observe();
    wr_t  e;
    logic legal;
    ack_seen = ack;
    legal = ((ack & ~req) == '0) && $onehot0(ack);
    check("ack_legal", legal, 1'b1);
    if (hb_clear) begin
      check("clear_with_wr", hb_wr_en, 1'b0);
      clears++;
      pass_no++;
      build_pass(pass_no);
      for (int p = 0; p < NPIX; p++) cnt[p] = 0;
    end
    if (hb_wr_en) begin
      writes++;
      check("wr_expected", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("wr_pixel", hb_pixel, e.pix);
        check("wr_data", hb_data, e.data);
        check("wr_pass", hb_pass, e.pass);
        if (exp_q.size() == 0) peak_wait = 3;
      end
    end
    if (done) dones++;
  endtask

  task automatic apply_env();
    int pi;
    hb_peak_done = 1'b0;
    if (auto_peak && peak_wait > 0) begin
      peak_wait--;
      if (peak_wait == 0) begin
        hb_peak_done = 1'b1;
        peak_wait    = -1;
      end
    end else if (auto_peak && exp_q.size() > 1 && $urandom_range(0, 29) == 0) begin
      hb_peak_done = 1'b1;  // must be ignored outside WAIT_PEAK
    end
    pi = (pass_no == 1) ? 1 : 0;
    for (int p = 0; p < NPIX; p++) begin
      if (ack_seen[p]) cnt[p]++;
      req[p] = en_mask[p] && (cnt[p] < NSMP) && ($urandom_range(0, 99) < req_pct);
      data_in[p*NP +: NP] = ts[pi][p][(cnt[p] < NSMP) ? cnt[p] : 0];
    end
  endtask

  task automatic tick();
    @(negedge clk);
    observe();
    @(posedge clk);
    #1;
    apply_env();
  endtask

  task automatic begin_seq();
    exp_q.delete();
    pass_no   = -1;
    clears    = 0;
    writes    = 0;
    dones     = 0;
    peak_wait = -1;
    for (int p = 0; p < NPIX; p++) cnt[p] = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run_full(input int budget);
    begin_seq();
    for (int i = 0; i < budget && dones == 0; i++) tick();
    check("seq_done", dones, 1);
    check("seq_clears", clears, 2);
    check("seq_writes", writes, 2*PASS_WR);
    check("seq_left", exp_q.size(), 0);
    tick();
    check("busy_after_done", busy, 1'b0);
  endtask

  // Control-corner vectors: inputs held for one cycle, outputs compared mid-cycle.
  typedef struct {
    logic            start, abort, peak;
    logic [NPIX-1:0] req;
    logic            busy, clear;
    logic [NPIX-1:0] ack;
    logic            wr;
    logic [1:0]      pix;
  } vec_t;

  vec_t vecs [15];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    for (int s = 0; s < 2; s++)
      for (int p = 0; p < NPIX; p++)
        for (int n = 0; n < NSMP; n++) ts[s][p][n] = NP'($urandom);

    vecs[0]  = '{1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0};
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b1, 4'b0000, 1'b0, 2'd0};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 4'b0100, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd0};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 4'b0100, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd0};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 4'b0101, 1'b1, 1'b0, 4'b0001, 1'b0, 2'd0};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 4'b0101, 1'b1, 1'b0, 4'b0001, 1'b1, 2'd0};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 4'b0100, 1'b1, 1'b0, 4'b0000, 1'b1, 2'd0};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 4'b0110, 1'b1, 1'b0, 4'b0010, 1'b0, 2'd0};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 4'b1111, 1'b1, 1'b0, 4'b0000, 1'b1, 2'd1};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 4'b1111, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd1};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd1};

    #23 res = 1'b1;
    @(negedge clk);
    check("reset_outputs", {ack, hb_wr_en, hb_data, hb_pixel, hb_pass, hb_clear, busy, done, err}, 0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 15; i++) begin
      start        = vecs[i].start;
      abort        = vecs[i].abort;
      hb_peak_done = vecs[i].peak;
      req          = vecs[i].req;
      @(negedge clk);
      check($sformatf("vec%0d_busy", i), busy, vecs[i].busy);
      check($sformatf("vec%0d_clear", i), hb_clear, vecs[i].clear);
      check($sformatf("vec%0d_ack", i), ack, vecs[i].ack);
      check($sformatf("vec%0d_wr", i), hb_wr_en, vecs[i].wr);
      check($sformatf("vec%0d_pixel", i), hb_pixel, vecs[i].pix);
      check($sformatf("vec%0d_done", i), done, 1'b0);
      check($sformatf("vec%0d_err", i), err, 1'b0);
      @(posedge clk);
      #1;
    end
    start = 1'b0; abort = 1'b0; hb_peak_done = 1'b0; req = '0;

    // Abort after ten writes, then a clean restart with all pixels always ready.
    req_pct = 100;
    begin_seq();
    for (int i = 0; i < 200 && writes < 10; i++) tick();
    check("abort_reached_10_writes", writes >= 10, 1'b1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("abort_idle", busy, 1'b0);
      check("abort_no_write", hb_wr_en, 1'b0);
    end
    run_full(400);
    check("err_clean", err, 1'b0);

    // Randomised request gaps with spurious peak_done pulses during acquisition.
    req_pct = 80;
    run_full(2000);

`ifdef HSEQ_TIMEOUT_EN
    en_mask   = 4'b1101;
    req_pct   = 100;
    auto_peak = 1'b0;
    begin_seq();
    for (int i = 0; i < 400 && !(clears == 1 && writes > 0 && exp_q.size() == 0); i++) tick();
    repeat (3) tick();
    check("to_writes", writes, 18);
    check("to_left", exp_q.size(), 0);
    check("to_err", err, 1'b1);
    check("to_busy", busy, 1'b1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();
    check("err_sticky_over_abort", err, 1'b1);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("err_cleared_by_start", err, 1'b0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();
    en_mask   = '1;
    auto_peak = 1'b1;
`endif

    // Asynchronous reset in the middle of acquisition.
    req_pct = 100;
    begin_seq();
    for (int i = 0; i < 8; i++) tick();
    check("pre_reset_busy", busy, 1'b1);
    #2 res = 1'b0;
    #1;
    check("async_reset_outputs", {ack, hb_wr_en, hb_data, hb_pixel, hb_pass, hb_clear, busy, done, err}, 0);
    @(negedge clk);
    check("async_reset_hold", {ack, hb_wr_en, busy}, 0);
    res = 1'b1;
    req = '0;
    @(negedge clk);
    check("after_reset_idle", busy, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
